// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default widths, FSM state
// encoding and downstream access-size codes.
package mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  // FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INST  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // ram_type access-size codes
  localparam logic [1:0] T_BYTE = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_WORD = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch, load and store.
// Exactly one downstream transaction is outstanding at a time.
// Optional feature macro MEM_ARB_RR_EN: round-robin between the data class
// (store/load) and the fetch class; without it, fixed priority
// store > load > fetch (fetch may starve).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_inst,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [1:0]    ld_type,
  output logic          ld_done,
  output logic [DW-1:0] ld_data,
  input  logic          st_req,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [1:0]    st_type,
  output logic          st_done,
  input  logic          flush,
  output logic          ram_r_req,
  output logic          ram_w_req,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic [1:0]    ram_type,
  output logic          inst_fe,
  output logic [AW-1:0] inst_fpc,
  input  logic          ram_done,
  input  logic [DW-1:0] ram_rdata,
  input  logic          inst_ok,
  input  logic [DW-1:0] inst_rdata
);

  logic [2:0]    state, state_nx, grant;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [1:0]    type_q;
  logic          res_cycle, st_ok, ld_ok, if_ok, data_ok, fetch_first;
  logic          is_data;
`ifdef MEM_ARB_RR_EN
  logic          last_data;
`endif

  // Grant selection and next-state logic
  always_comb begin
    // The cycle carrying a registered ld_done/if_done is a turnaround cycle:
    // the requester still holds its req, so nothing is granted here.
    res_cycle = ld_done | if_done;
    st_ok     = st_req & ~res_cycle;
    ld_ok     = ld_req & ~res_cycle;
    if_ok     = if_req & ~res_cycle & ~flush;
    data_ok   = st_ok | ld_ok;
`ifdef MEM_ARB_RR_EN
    fetch_first = if_ok & (~data_ok | last_data);
`else
    fetch_first = if_ok & ~data_ok;
`endif
    grant = S_IDLE;
    if (fetch_first)  grant = S_INST;
    else if (st_ok)   grant = S_STORE;
    else if (ld_ok)   grant = S_LOAD;

    state_nx = state;
    case (state)
      S_IDLE:  state_nx = grant;
      S_INST:  if (flush)         state_nx = inst_ok ? S_IDLE : S_DRAIN;
               else if (inst_ok)  state_nx = S_IDLE;
      S_LOAD:  if (ram_done)      state_nx = S_IDLE;
      S_STORE: if (ram_done)      state_nx = S_IDLE;
      // Dropping inst_fe aborts the fetch; DRAIN swallows a late inst_ok.
      S_DRAIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state, latched request copy and registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      type_q  <= '0;
      ld_done <= 1'b0;
      ld_data <= '0;
      if_done <= 1'b0;
      if_inst <= '0;
`ifdef MEM_ARB_RR_EN
      last_data <= 1'b0;
`endif
    end else if (rdy) begin
      state   <= state_nx;
      ld_done <= 1'b0;
      if_done <= 1'b0;
      if (state == S_IDLE) begin
        case (grant)
          S_STORE: begin addr_q <= st_addr; data_q <= st_data; type_q <= st_type; end
          S_LOAD:  begin addr_q <= ld_addr; data_q <= '0;      type_q <= ld_type; end
          S_INST:  begin addr_q <= if_addr; data_q <= '0;      type_q <= T_WORD;  end
          default: ;
        endcase
`ifdef MEM_ARB_RR_EN
        if (grant != S_IDLE) last_data <= (grant != S_INST);
`endif
      end
      if (state == S_LOAD && ram_done) begin
        ld_done <= 1'b1;
        ld_data <= ram_rdata;
      end
      if (state == S_INST && inst_ok && !flush) begin
        if_done <= 1'b1;
        if_inst <= inst_rdata;
      end
    end
  end

  // Downstream requests are decoded from state so they clear with reset
  assign is_data   = (state == S_LOAD) || (state == S_STORE);
  assign ram_r_req = (state == S_LOAD);
  assign ram_w_req = (state == S_STORE);
  assign inst_fe   = (state == S_INST);
  assign ram_addr  = is_data ? addr_q : '0;
  assign ram_type  = is_data ? type_q : '0;
  assign ram_data  = (state == S_STORE) ? data_q : '0;
  assign inst_fpc  = (state == S_INST) ? addr_q : '0;
  assign st_done   = rdy && (state == S_STORE) && ram_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single-transaction vectors
// plus hand-written sequences for arbitration order, flush, stall and reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int K_ST = 0, K_LD = 1, K_IF = 2;

  logic        clk = 1'b0, rst, rdy;
  logic        if_req, ld_req, st_req, flush, ram_done, inst_ok;
  logic [31:0] if_addr, ld_addr, st_addr, st_data, ram_rdata, inst_rdata;
  logic [1:0]  ld_type, st_type;
  logic        if_done, ld_done, st_done, ram_r_req, ram_w_req, inst_fe;
  logic [31:0] if_inst, ld_data, ram_addr, ram_data, inst_fpc;
  logic [1:0]  ram_type;

  int checks = 0, errors = 0, ovl;
  bit timeout;
  int order[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_type(st_type), .st_done(st_done),
    .flush(flush), .ram_r_req(ram_r_req), .ram_w_req(ram_w_req), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_type(ram_type), .inst_fe(inst_fe), .inst_fpc(inst_fpc),
    .ram_done(ram_done), .ram_rdata(ram_rdata), .inst_ok(inst_ok), .inst_rdata(inst_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr, wdata;
    logic [1:0]  typ;
    int          lat;
    logic [31:0] rdata;
    logic [2:0]  exp_bits;   // {ram_r_req, ram_w_req, inst_fe} while busy
    logic [31:0] exp_addr, exp_wdata;
    logic [1:0]  exp_type;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[6];
  vec_t v200;

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    case (v.kind)
      K_ST:    begin st_req = 1; st_addr = v.addr; st_data = v.wdata; st_type = v.typ; end
      K_LD:    begin ld_req = 1; ld_addr = v.addr; ld_type = v.typ; end
      default: begin if_req = 1; if_addr = v.addr; end
    endcase
    tick();
    // Scramble request fields: downstream must use the registered copy
    st_addr = 32'ha5a5a5a5; st_data = 32'h5a5a5a5a; ld_addr = 32'ha5a5a5a5;
    if_addr = 32'ha5a5a5a5; st_type = ~v.typ; ld_type = ~v.typ;
    for (int c = 0; c <= v.lat; c++) begin
      chk($sformatf("v%0d_bits_c%0d", idx, c), {ram_r_req, ram_w_req, inst_fe}, v.exp_bits);
      if (v.kind == K_IF) chk($sformatf("v%0d_fpc", idx), inst_fpc, v.exp_addr);
      else begin
        chk($sformatf("v%0d_addr", idx), ram_addr, v.exp_addr);
        chk($sformatf("v%0d_type", idx), ram_type, v.exp_type);
        if (v.kind == K_ST) chk($sformatf("v%0d_wdata", idx), ram_data, v.exp_wdata);
      end
      if (c == v.lat) begin
        if (v.kind == K_IF) begin inst_ok = 1; inst_rdata = v.rdata; end
        else begin ram_done = 1; ram_rdata = v.rdata; end
      end
      #1;
      if (v.kind == K_ST) chk($sformatf("v%0d_st_done_c%0d", idx, c), st_done, c == v.lat);
      tick();
    end
    ram_done = 0; inst_ok = 0; ram_rdata = 32'hbad0bad0; inst_rdata = 32'hbad0bad0;
    chk($sformatf("v%0d_idle", idx), {ram_r_req, ram_w_req, inst_fe}, 3'b000);
    if (v.kind == K_LD) begin
      chk($sformatf("v%0d_ld_done", idx), ld_done, 1);
      chk($sformatf("v%0d_ld_data", idx), ld_data, v.exp_res);
    end else if (v.kind == K_IF) begin
      chk($sformatf("v%0d_if_done", idx), if_done, 1);
      chk($sformatf("v%0d_if_inst", idx), if_inst, v.exp_res);
    end else st_req = 0;
    tick();
    // ld/if req was still held across the done cycle: no re-grant allowed
    ld_req = 0; if_req = 0;
    chk($sformatf("v%0d_no_regrant", idx), {ram_r_req, ram_w_req, inst_fe, ld_done, if_done}, 5'b0);
    tick();
    chk($sformatf("v%0d_quiet", idx), {ram_r_req, ram_w_req, inst_fe}, 3'b000);
  endtask

  // Auto-responder: completes each downstream transaction in its 2nd cycle.
  // hold=1 keeps requests asserted and stops after max_grants grants.
  task automatic auto_run(input int budget, input int max_grants, input bit hold);
    int age;
    bit pr, pw, pf, pldd, pifd, stc;
    age = 0; pr = 0; pw = 0; pf = 0; pldd = 0; pifd = 0; stc = 0;
    order.delete(); ovl = 0; timeout = 1;
    for (int c = 0; c < budget; c++) begin
      tick();
      ram_done = 0; inst_ok = 0;
      if (!hold) begin
        if (pldd) ld_req = 0;
        if (pifd) if_req = 0;
        if (stc)  st_req = 0;
      end
      pldd = ld_done; pifd = if_done; stc = 0;
      if ((ram_r_req && ram_w_req) || (inst_fe && (ram_r_req || ram_w_req))) ovl++;
      if (ram_w_req && !pw) order.push_back(K_ST);
      if (ram_r_req && !pr) order.push_back(K_LD);
      if (inst_fe && !pf)   order.push_back(K_IF);
      pr = ram_r_req; pw = ram_w_req; pf = inst_fe;
      if (hold && order.size() >= max_grants) begin timeout = 0; break; end
      if (ram_r_req || ram_w_req || inst_fe) begin
        age++;
        if (age == 2) begin
          ram_done = ram_r_req | ram_w_req; inst_ok = inst_fe; stc = ram_w_req;
          ram_rdata = 32'h600d0000 | c; inst_rdata = 32'h11110000 | c; age = 0;
        end
      end else age = 0;
      if (!hold && !st_req && !ld_req && !if_req && !ram_r_req && !ram_w_req && !inst_fe &&
          !ld_done && !if_done) begin timeout = 0; break; end
    end
  endtask

  initial begin
    vecs[0] = '{K_IF, 32'h100,        32'h0,        T_WORD, 8, 32'h00000013,
                3'b001, 32'h100,        32'h0,        T_WORD, 32'h00000013};
    vecs[1] = '{K_ST, 32'h2000,       32'hdeadbeef, T_WORD, 3, 32'h0,
                3'b010, 32'h2000,       32'hdeadbeef, T_WORD, 32'h0};
    vecs[2] = '{K_LD, 32'h3004,       32'h0,        T_HALF, 1, 32'h0000beef,
                3'b100, 32'h3004,       32'h0,        T_HALF, 32'h0000beef};
    vecs[3] = '{K_LD, 32'h3001,       32'h0,        T_BYTE, 0, 32'h000000ff,
                3'b100, 32'h3001,       32'h0,        T_BYTE, 32'h000000ff};
    vecs[4] = '{K_ST, 32'h40,         32'h55,       T_BYTE, 0, 32'h0,
                3'b010, 32'h40,         32'h55,       T_BYTE, 32'h0};
    vecs[5] = '{K_IF, 32'hfffffffc,   32'h0,        T_WORD, 2, 32'hcafef00d,
                3'b001, 32'hfffffffc,   32'h0,        T_WORD, 32'hcafef00d};
    v200    = '{K_IF, 32'h200,        32'h0,        T_WORD, 1, 32'h00a00093,
                3'b001, 32'h200,        32'h0,        T_WORD, 32'h00a00093};

    rst = 0; rdy = 1; flush = 0; ram_done = 0; inst_ok = 0;
    if_req = 0; ld_req = 0; st_req = 0;
    if_addr = 0; ld_addr = 0; st_addr = 0; st_data = 0; ld_type = 0; st_type = 0;
    ram_rdata = 32'hbad0bad0; inst_rdata = 32'hbad0bad0;

    // Reset state
    #12;
    chk("rst_ctrl", {ram_r_req, ram_w_req, inst_fe, if_done, ld_done, st_done}, 6'b0);
    chk("rst_addr", {ram_addr, inst_fpc}, 64'h0);
    chk("rst_data", {if_inst, ld_data}, 64'h0);
    chk("rst_wdata", {ram_data, 30'h0, ram_type}, 64'h0);
    tick(); rst = 1;

    // Single-transaction vectors
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // All three requests at once. Fixed priority: ST, LD, IF. With the
    // round-robin flag, the last grant was a fetch, so data goes first
    // (store), then the flag hands the next grant to fetch, then load.
    st_req = 1; st_addr = 32'h700; st_data = 32'h1; st_type = T_WORD;
    ld_req = 1; ld_addr = 32'h704; ld_type = T_WORD;
    if_req = 1; if_addr = 32'h708;
    auto_run(100, 0, 0);
    chk("three_timeout", timeout, 0);
    chk("three_overlap", ovl, 0);
    chk("three_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("three_first", order[0], K_ST);
`ifdef MEM_ARB_RR_EN
      chk("three_second", order[1], K_IF);
      chk("three_third", order[2], K_LD);
`else
      chk("three_second", order[1], K_LD);
      chk("three_third", order[2], K_IF);
`endif
    end
    tick();

    // Flush two cycles into a fetch: DRAIN drops inst_fe, late inst_ok discarded
    if_req = 1; if_addr = 32'h180;
    tick();
    chk("fl_fe", {inst_fe, inst_fpc}, {1'b1, 32'h180});
    tick(); tick();
    flush = 1; if_req = 0;
    tick();
    chk("fl_drain_fe", {ram_r_req, ram_w_req, inst_fe}, 3'b000);
    flush = 0; inst_ok = 1; inst_rdata = 32'hdeaddead;
    tick();
    inst_ok = 0;
    chk("fl_no_done1", if_done, 0);
    tick();
    chk("fl_no_done2", {if_done, inst_fe}, 2'b00);
    run_vec(10, v200);

    // Flush coincident with inst_ok: result discarded
    if_req = 1; if_addr = 32'h300;
    tick();
    flush = 1; inst_ok = 1; inst_rdata = 32'h77777777; if_req = 0;
    tick();
    flush = 0; inst_ok = 0;
    chk("flok_state", {inst_fe, if_done}, 2'b00);
    tick();
    chk("flok_no_done", if_done, 0);

    // Flush in IDLE suppresses a same-cycle if_req
    if_req = 1; if_addr = 32'h400; flush = 1;
    tick();
    chk("fl_idle", inst_fe, 0);
    if_req = 0; flush = 0;
    tick();

    // rdy low for 5 cycles mid-STORE with ram_done already high
    st_req = 1; st_addr = 32'h600; st_data = 32'h77; st_type = T_HALF;
    tick(); tick();
    rdy = 0; ram_done = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rdy_st_done_%0d", c), st_done, 0);
      tick();
      chk($sformatf("rdy_frozen_%0d", c), {ram_w_req, ram_addr, ram_data[15:0], ram_type},
          {1'b1, 32'h600, 16'h77, T_HALF});
    end
    rdy = 1;
    #1;
    chk("rdy_st_done", st_done, 1);
    tick();
    ram_done = 0; st_req = 0;
    chk("rdy_idle", ram_w_req, 0);
    tick();

    // Continuous ld_req + if_req
    ld_req = 1; ld_addr = 32'h800; ld_type = T_WORD; if_req = 1; if_addr = 32'h900;
    auto_run(200, 4, 1);
    chk("rr_timeout", timeout, 0);
    for (int i = 0; i < order.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      if (i > 0) chk($sformatf("rr_alt_%0d", i), order[i] != order[i-1], 1);
`else
      chk($sformatf("fixed_ld_%0d", i), order[i], K_LD);
`endif
    end
    ld_req = 0; if_req = 0;
    auto_run(50, 0, 0);
    chk("rr_drain", timeout, 0);
    tick();

    // Reset in the middle of a LOAD
    ld_req = 1; ld_addr = 32'h500; ld_type = T_WORD;
    tick(); tick();
    chk("rl_busy", ram_r_req, 1);
    rst = 0; #1;
    chk("rl_ctrl", {ram_r_req, ram_w_req, inst_fe, ld_done, if_done}, 5'b0);
    chk("rl_addr", {ram_addr, 30'h0, ram_type}, 64'h0);
    chk("rl_data", {ld_data, if_inst}, 64'h0);
    ld_req = 0;
    tick(); rst = 1;
    tick();
    ram_done = 1; ram_rdata = 32'h12345678;
    tick();
    ram_done = 0;
    chk("rl_no_done1", {ld_done, ram_r_req}, 2'b00);
    tick();
    chk("rl_no_done2", {ld_done, ld_data}, 33'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AW, 32, address width; DW, 32, data/instruction width.
REQ-002 SHALL have port clk  in  1  system clock, all state on posedge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy  in  1  global enable; when low, all state and outputs hold.
REQ-005 SHALL have ports if_req in 1 and if_addr in AW: instruction fetch request and PC; if_done out 1 and if_inst out DW: one-cycle fetch result.
REQ-006 SHALL have ports ld_req in 1, ld_addr in AW, ld_type in 2: load request and size; ld_done out 1 and ld_data out DW: one-cycle load result.
REQ-007 SHALL have ports st_req in 1, st_addr in AW, st_data in DW, st_type in 2: store request; st_done out 1: one-cycle store completion.
REQ-008 SHALL have port flush  in  1  branch mispredict; cancels the outstanding or pending fetch.
REQ-009 SHALL have downstream ports ram_r_req, ram_w_req out 1; ram_addr out AW; ram_data out DW; ram_type out 2; inst_fe out 1; inst_fpc out AW.
REQ-010 SHALL have downstream ports ram_done in 1, ram_rdata in DW, inst_ok in 1, inst_rdata in DW.

Function
REQ-011 SHALL implement states IDLE, INST, LOAD, STORE, DRAIN, and keep exactly one downstream transaction outstanding.
REQ-012 In IDLE, SHALL grant in order: st_req, then ld_req, then if_req (subject to REQ-022), latching addr/data/type into internal registers in the grant cycle.
REQ-013 Grant SHALL drive the matching downstream request from the registered copy, starting the cycle after the grant, and hold it through the completion cycle.
REQ-014 STORE SHALL go to IDLE on ram_done, pulsing st_done for one cycle in that same cycle.
REQ-015 LOAD SHALL go to IDLE on ram_done, registering ram_rdata to ld_data and pulsing ld_done for one cycle on the next cycle.
REQ-016 INST SHALL go to IDLE on inst_ok, registering inst_rdata to if_inst and pulsing if_done for one cycle on the next cycle.
REQ-017 flush in INST SHALL deassert inst_fe and enter DRAIN; DRAIN SHALL discard inst_ok (no if_done) and then return to IDLE.
REQ-018 flush in IDLE or in a data state SHALL suppress any if_req sampled that cycle; data transactions are never cancelled.
REQ-019 flush together with inst_ok in INST SHALL discard the result and go to IDLE.
REQ-020 Requesters SHALL hold req until their done pulse; the arbiter SHALL NOT re-grant the same request in the done cycle.
REQ-021 ram_r_req and ram_w_req SHALL never be high together; inst_fe SHALL be low whenever either is high.
REQ-022 In IDLE, an if_req SHALL NOT be granted when st_req or ld_req is pending, except as provided by MEM_ARB_RR_EN.

Reset
REQ-023 On rst low, SHALL enter IDLE and clear all outputs and latched registers to zero at once, including a mid-transaction reset.
REQ-024 After rst rises, SHALL accept a grant no earlier than the first rising clock edge.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: a 1-bit last-grant flag alternates between the data class and the fetch class when both are pending; store still precedes load within the data class.
REQ-026 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-012, and fetch can starve.

Structure
REQ-027 State encoding, the ram_type codes (00 byte, 01 half, 11 word) and the AW/DW defaults SHALL live in the shared package.
REQ-028 No sub-modules; a single always_ff FSM SHALL be used, with combinational next-state and grant logic.

Verification
REQ-029 if_req addr 0x100, inst_ok and inst_rdata 0x00000013 after 8 cycles -> inst_fe with inst_fpc 0x100 held, then an if_done pulse with if_inst 0x13.
REQ-030 st_req, ld_req and if_req asserted in the same cycle -> order STORE, LOAD, INST, with no overlap of downstream requests.
REQ-031 flush 2 cycles into INST -> inst_fe drops, DRAIN, no if_done, then IDLE; a subsequent if_req 0x200 is served correctly.
REQ-032 rst low during LOAD -> all outputs zero immediately; a later ram_done produces no ld_done.
REQ-033 MEM_ARB_RR_EN defined, with ld_req and if_req continuously asserted -> grants alternate LOAD/INST; undefined -> LOAD only.
REQ-034 rdy low for 5 cycles mid-STORE -> outputs frozen, and st_done occurs after rdy returns with ram_done.
